// File: rtl/usb_ep_rx_pkt_buffer_if.sv
// Packet handshake from the endpoint engine and byte stream to the consumer.
// Both channels transfer on a cycle where valid and ready are high together; valid never waits on ready.
interface usb_ep_rx_pkt_buffer_if #(
    parameter int MAX_PKT = 8
);
    logic                         i_erValid;
    logic [8*MAX_PKT-1:0]         i_erData;
    logic [$clog2(MAX_PKT):0]     i_erData_nBytes;
    logic                         o_erReady;

    logic                         o_valid;
    logic [7:0]                   o_data;
    logic                         o_last;
    logic                         i_ready;

    modport slave (
        input  i_erValid, i_erData, i_erData_nBytes, i_ready,
        output o_erReady, o_valid, o_data, o_last
    );

    modport master (
        output i_erValid, i_erData, i_erData_nBytes, i_ready,
        input  o_erReady, o_valid, o_data, o_last
    );
endinterface

// File: rtl/usb_ep_rx_pkt_buffer.sv
// Receive packet buffer: latches a whole endpoint packet, unloads it one byte per
// cycle into a byte FIFO tagged with a last-byte flag, and streams it downstream.
module usb_ep_rx_pkt_buffer #(
    parameter int MAX_PKT    = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MARK_LAST  = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_flush,
    input  logic                          i_halt,
    input  logic                          i_clearHalt,
    usb_ep_rx_pkt_buffer_if.slave         bus,
    output logic                          o_erStall,
    output logic [$clog2(FIFO_DEPTH):0]   o_nBytes,
    output logic                          o_errOverlen,
    output logic                          o_zlp,
    output logic                          dbg_state
);
    localparam int LW = $clog2(MAX_PKT) + 1;
    localparam int IW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LW-1:0] MAX_LEN     = LW'(MAX_PKT);
    localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - MAX_PKT);
    localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

    typedef enum logic [0:0] { IDLE = 1'b0, UNLOAD = 1'b1 } state_t;

    state_t          state_q, state_d;
    logic [7:0]      pkt_q [MAX_PKT];
    logic [LW-1:0]   len_q;
    logic [IW-1:0]   idx_q;
    logic            halted_q, zlp_q, overlen_q;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q;

    logic            er_ready, accept, push, push_last, pop;
    logic [LW-1:0]   len_in;

    assign len_in    = (bus.i_erData_nBytes > MAX_LEN) ? MAX_LEN : bus.i_erData_nBytes;
    assign accept    = er_ready && bus.i_erValid;
    assign push      = (state_q == UNLOAD);
    assign push_last = push && (LW'(idx_q) == len_q - LW'(1));
    assign pop       = bus.i_ready && bus.o_valid;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Space for a full MAX_PKT packet is reserved at accept time, so UNLOAD never stalls.
    always_comb begin
        state_d  = state_q;
        er_ready = (state_q == IDLE) && !halted_q && !i_flush && (cnt_q <= SPACE_LIMIT);
        case (state_q)
            IDLE:    if (accept && (bus.i_erData_nBytes != '0)) state_d = UNLOAD;
            UNLOAD:  if (push_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush) state_d = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < MAX_PKT; k++) pkt_q[k] <= bus.i_erData[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !i_flush) mem[wr_ptr_q] <= {push_last, pkt_q[idx_q]};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            len_q     <= '0;
            idx_q     <= '0;
            halted_q  <= 1'b0;
            zlp_q     <= 1'b0;
            overlen_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            zlp_q     <= accept && (bus.i_erData_nBytes == '0);
            overlen_q <= accept && (bus.i_erData_nBytes > MAX_LEN);
            halted_q  <= i_halt || (halted_q && !i_clearHalt);
            if (i_flush) begin
                idx_q    <= '0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (accept) begin
                    len_q <= len_in;
                    idx_q <= '0;
                end else if (push) begin
                    idx_q <= idx_q + IW'(1);
                end
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push && !pop)      cnt_q <= cnt_q + CW'(1);
                else if (!push && pop) cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign bus.o_erReady = er_ready;
    assign bus.o_valid   = (cnt_q != '0);
    assign bus.o_data    = mem[rd_ptr_q][7:0];
    assign bus.o_last    = (MARK_LAST != 0) && bus.o_valid && mem[rd_ptr_q][8];
    assign o_erStall     = halted_q;
    assign o_nBytes      = cnt_q;
    assign o_errOverlen  = overlen_q;
    assign o_zlp         = zlp_q;
    assign dbg_state     = (state_q == UNLOAD);

    assert property (@(posedge i_clk) disable iff (!i_rstn)
        !(push && !i_flush && !pop && (cnt_q == FULL_CNT)));
endmodule

// File: tb/tb_usb_ep_rx_pkt_buffer.sv
// Directed and random stimulus against a queue-based packet/FIFO model, checked every cycle.
module tb_usb_ep_rx_pkt_buffer;
    localparam int MAX_PKT    = 8;
    localparam int FIFO_DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n, flush, halt, clr;
    logic [$clog2(FIFO_DEPTH):0] n_bytes;
    logic zlp, ovl, stall, dbg;

    int total = 0;
    int bad   = 0;

    logic [8:0] m_fifo[$];
    logic [8:0] m_pend[$];
    bit         m_halt, m_zlp, m_ovl;

    usb_ep_rx_pkt_buffer_if #(.MAX_PKT(MAX_PKT)) bus();

    usb_ep_rx_pkt_buffer #(.MAX_PKT(MAX_PKT), .FIFO_DEPTH(FIFO_DEPTH), .MARK_LAST(1)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_flush(flush), .i_halt(halt), .i_clearHalt(clr),
        .bus(bus), .o_erStall(stall), .o_nBytes(n_bytes), .o_errOverlen(ovl),
        .o_zlp(zlp), .dbg_state(dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // A new packet is taken only when nothing is left to unload and a full packet fits.
    function automatic bit m_ready();
        return (m_pend.size() == 0) && !m_halt && !flush && ((FIFO_DEPTH - m_fifo.size()) >= MAX_PKT);
    endfunction

    task automatic model_reset();
        m_fifo.delete(); m_pend.delete();
        m_halt = 0; m_zlp = 0; m_ovl = 0;
    endtask

    task automatic model_edge();
        bit acc, pop;
        int nb, len;
        logic [8:0] e;
        nb  = int'(bus.i_erData_nBytes);
        acc = m_ready() && bus.i_erValid;
        pop = bus.i_ready && (m_fifo.size() != 0);
        m_zlp = acc && (nb == 0);
        m_ovl = acc && (nb > MAX_PKT);
        if (flush) begin
            m_fifo.delete(); m_pend.delete();
        end else begin
            if (pop) e = m_fifo.pop_front();
            if (m_pend.size() != 0) m_fifo.push_back(m_pend.pop_front());
            if (acc && nb != 0) begin
                len = (nb > MAX_PKT) ? MAX_PKT : nb;
                for (int k = 0; k < len; k++) m_pend.push_back({(k == len - 1), bus.i_erData[8*k +: 8]});
            end
        end
        m_halt = halt || (m_halt && !clr);
    endtask

    task automatic check_all();
        chk("valid", 32'(bus.o_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            chk("data", 32'(bus.o_data), 32'(m_fifo[0][7:0]));
            chk("last", 32'(bus.o_last), 32'(m_fifo[0][8]));
        end
        chk("n_bytes", 32'(n_bytes), 32'(m_fifo.size()));
        chk("er_ready", 32'(bus.o_erReady), 32'(m_ready()));
        chk("stall", 32'(stall), 32'(m_halt));
        chk("zlp", 32'(zlp), 32'(m_zlp));
        chk("overlen", 32'(ovl), 32'(m_ovl));
        chk("state", 32'(dbg), 32'(m_pend.size() != 0));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input int nb, input logic [8*MAX_PKT-1:0] d);
        int guard = 0;
        bit done = 0;
        bus.i_erValid = 1'b1;
        bus.i_erData = d;
        bus.i_erData_nBytes = ($clog2(MAX_PKT)+1)'(nb);
        while (!done && guard < 200) begin
            done = m_ready();
            tick();
            guard++;
        end
        bus.i_erValid = 1'b0;
        if (!done) begin
            total++; bad++;
            $error("FAIL send_timeout observed=%0d expected=accept", guard);
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int guard = 0;
        bus.i_ready = 1'b1;
        while ((m_fifo.size() != 0 || m_pend.size() != 0) && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            total++; bad++;
            $error("FAIL drain_timeout observed=%0d expected=empty", m_fifo.size());
        end
    endtask

    function automatic logic [8*MAX_PKT-1:0] rand_pkt();
        logic [8*MAX_PKT-1:0] d;
        for (int k = 0; k < MAX_PKT; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 0; halt = 0; clr = 0;
        bus.i_erValid = 0; bus.i_erData = '0; bus.i_erData_nBytes = '0; bus.i_ready = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_valid", 32'(bus.o_valid), 0);
        chk("reset_n_bytes", 32'(n_bytes), 0);
        chk("reset_er_ready", 32'(bus.o_erReady), 1);
        chk("reset_stall", 32'(stall), 0);
        tick();

        // Three-byte packet streamed straight through.
        bus.i_ready = 1'b1;
        send(3, 64'h0000_0000_0033_2211);
        idle_ticks(6);

        // Two full packets with the consumer stalled fill the FIFO exactly.
        bus.i_ready = 1'b0;
        send(8, rand_pkt());
        send(8, rand_pkt());
        idle_ticks(9);
        chk("full_n_bytes", 32'(n_bytes), 16);
        chk("full_er_ready", 32'(bus.o_erReady), 0);
        for (int i = 0; i < 8; i++) begin
            bus.i_ready = 1'b1; tick();
            bus.i_ready = 1'b0; tick();
        end
        #1 chk("space_er_ready", 32'(bus.o_erReady), 1);
        drain();

        // Zero-length packet, then an overlong one clamped to MAX_PKT bytes.
        bus.i_ready = 1'b0;
        send(0, rand_pkt());
        #1 chk("zlp_pulse", 32'(zlp), 1);
        tick();
        send(9, rand_pkt());
        #1 chk("overlen_pulse", 32'(ovl), 1);
        idle_ticks(10);
        chk("overlen_bytes", 32'(n_bytes), 8);
        drain();

        // Halt during an unload keeps every byte; set wins over clear.
        bus.i_ready = 1'b1;
        send(4, rand_pkt());
        halt = 1'b1; tick(); halt = 1'b0;
        idle_ticks(6);
        chk("halt_stall", 32'(stall), 1);
        chk("halt_er_ready", 32'(bus.o_erReady), 0);
        halt = 1'b1; clr = 1'b1; tick(); halt = 1'b0; clr = 1'b0;
        idle_ticks(2);
        clr = 1'b1; tick(); clr = 1'b0;
        idle_ticks(2);

        // Flush while bytes are buffered and a packet is still unloading.
        bus.i_ready = 1'b0;
        send(5, rand_pkt());
        idle_ticks(5);
        send(3, rand_pkt());
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_valid", 32'(bus.o_valid), 0);
        chk("flush_n_bytes", 32'(n_bytes), 0);
        chk("flush_state", 32'(dbg), 0);
        idle_ticks(3);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.i_erValid = ($urandom_range(0, 2) == 0);
            bus.i_erData = rand_pkt();
            bus.i_erData_nBytes = ($clog2(MAX_PKT)+1)'($urandom_range(0, MAX_PKT + 2));
            bus.i_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 99) == 0);
            halt  = ($urandom_range(0, 149) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.i_erValid = 0; flush = 0; halt = 0; clr = 1'b1;
        tick();
        clr = 1'b0;
        drain();

        // Asynchronous reset in the middle of an unload.
        bus.i_ready = 1'b0;
        send(8, rand_pkt());
        halt = 1'b1; tick(); halt = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 0);
        chk("arst_last", 32'(bus.o_last), 0);
        chk("arst_n_bytes", 32'(n_bytes), 0);
        chk("arst_stall", 32'(stall), 0);
        chk("arst_state", 32'(dbg), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.i_ready = 1'b1;
        #1 chk("arst_er_ready", 32'(bus.o_erReady), 1);
        idle_ticks(4);
        send(2, rand_pkt());
        idle_ticks(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/usb_ep_rx_pkt_buffer.md
USB_EP_RX_PKT_BUFFER -- requirements
Module: usb_ep_rx_pkt_buffer

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, maximum packet payload in bytes (power of 2, >=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, byte FIFO entries (power of 2, >= MAX_PKT).
REQ-003 SHALL have parameter MARK_LAST, default 1, enables o_last packet-boundary flag (0: o_last tied 0).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 i_clk  input  1  clock, all state on rising edge.
REQ-006 i_rstn  input  1  asynchronous active-low reset.
REQ-007 i_flush  input  1  discard FIFO contents and abort any unload in progress.
REQ-008 i_halt  input  1  set endpoint halt (SET_FEATURE ENDPOINT_HALT).
REQ-009 i_clearHalt  input  1  clear endpoint halt.
REQ-010 i_ready  input  1  downstream consumer ready.
REQ-011 o_valid  output  1  byte available downstream.
REQ-012 o_data  output  8  downstream byte.
REQ-013 o_last  output  1  o_data is last byte of its packet.
REQ-014 o_erStall  output  1  endpoint halted; host sees STALL.
REQ-015 o_erReady  output  1  block can accept a packet from endpoint engine.
REQ-016 i_erValid  input  1  packet offered by endpoint engine.
REQ-017 i_erData  input  8*MAX_PKT  payload, byte k at bits [8k+7:8k].
REQ-018 i_erData_nBytes  input  $clog2(MAX_PKT)+1  payload length, 0..MAX_PKT.
REQ-019 o_nBytes  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-020 o_errOverlen  output  1  one-cycle pulse: accepted packet had nBytes > MAX_PKT.
REQ-021 o_zlp  output  1  one-cycle pulse: zero-length packet accepted.

Function
REQ-022 Packet accept = o_erReady && i_erValid; byte pop = i_ready && o_valid.
REQ-023 FSM states IDLE, UNLOAD only.
REQ-024 o_erReady SHALL be 1 only in IDLE, with !halted_q, !i_flush, and free entries (FIFO_DEPTH - o_nBytes) >= MAX_PKT.
REQ-025 IDLE, accept, nBytes==0: pulse o_zlp next cycle, nothing pushed, stay IDLE.
REQ-026 IDLE, accept, nBytes>0: latch i_erData and length (clamped to MAX_PKT), index=0, go UNLOAD next cycle.
REQ-027 nBytes>MAX_PKT: clamp to MAX_PKT, pulse o_errOverlen cycle after accept.
REQ-028 UNLOAD: push latched byte[index] every cycle, index+1; push with index==len-1 carries last=1 and returns FSM to IDLE next cycle.
REQ-029 Throughput: n-byte packet occupies n UNLOAD cycles; next accept earliest first IDLE cycle after.
REQ-030 FIFO SHALL never overflow (space reserved by REQ-024); push when full is a design error (assertion).
REQ-031 FIFO stores {last, data}; o_valid = !empty; o_data/o_last from head entry; pushed byte visible at o_valid the cycle after push.
REQ-032 Simultaneous push and pop: occupancy unchanged; pop when empty ignored.
REQ-033 Read/write pointers wrap modulo FIFO_DEPTH; o_nBytes range 0..FIFO_DEPTH.
REQ-034 i_flush: next cycle FIFO empty, o_nBytes=0, FSM IDLE, latched packet discarded; flush beats same-cycle push/pop/accept.
REQ-035 halted_q: set by i_halt, cleared by i_clearHalt, set wins if both; o_erStall = halted_q.
REQ-036 Halt SHALL NOT abort an UNLOAD in progress nor drop buffered bytes; it only blocks new accepts.
REQ-037 o_data undefined/don't-care while o_valid=0.

Reset
REQ-038 On i_rstn=0 (async): FSM IDLE, FIFO empty, o_valid=0, o_last=0, o_nBytes=0, halted_q=0, o_erStall=0, o_errOverlen=0, o_zlp=0, index=0.
REQ-039 Reset mid-UNLOAD discards the partial packet; first cycle after deassertion o_erReady=1.

Verification
REQ-040 3-byte packet {0x11,0x22,0x33}, i_ready=1 -> o_data 0x11,0x22,0x33 on consecutive cycles, o_last only with 0x33, o_erReady low 3 cycles.
REQ-041 i_ready=0, MAX_PKT=8, FIFO_DEPTH=16, two 8-byte packets -> o_nBytes=16, o_erReady stays 0 until one pop, returns 1 only when free>=8.
REQ-042 nBytes=0 -> o_zlp pulse, o_nBytes stays 0; nBytes=9 (MAX_PKT=8) -> o_errOverlen pulse, exactly 8 bytes pushed.
REQ-043 i_halt during 4-byte UNLOAD -> all 4 bytes delivered, o_erStall=1, o_erReady=0 until i_clearHalt; i_halt&&i_clearHalt same cycle -> stays halted.
REQ-044 i_flush with 5 bytes buffered and UNLOAD active -> next cycle o_valid=0, o_nBytes=0, FSM IDLE.
REQ-045 i_rstn asserted mid-UNLOAD, asynchronous to i_clk -> outputs at REQ-038 values immediately, no stale byte after release.
